// File: rtl/spi_dev_proto.sv
// Frames SPI chip-select transactions into a byte write-strobe bus and returns MISO bytes.
// Write path: one cycle from usr_mosi_stb to pw_wstb. pw_end follows the end of a transaction by two cycles.
// No back-pressure: a strobe is emitted for every accepted byte.
module spi_dev_proto #(
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int unsigned BCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        usr_mosi_data,
  input  logic              usr_mosi_stb,
  output logic [7:0]        usr_miso_data,
  input  logic              usr_miso_ack,
  input  logic              csn_fall,
  input  logic              csn_rise,
  input  logic [7:0]        status,
  output logic [7:0]        pw_wdata,
  output logic              pw_wcmd,
  output logic              pw_wstb,
  output logic [BCNT_W-1:0] pw_bcnt,
  input  logic [7:0]        pw_rdata,
  input  logic              pw_rstb,
  output logic              pw_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    ENDT = 2'd3
  } state_t;

  state_t              state_q;
  logic                restart_q;
  logic [7:0]          wdata_q;
  logic                wcmd_q;
  logic                wstb_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic                end_q;
  logic [7:0]          buf_q;
  logic                buf_vld_q;
  logic                enter_cmd_d;

  // A transaction (re)starts on csn_fall from IDLE, or on leaving END after a missed csn_rise.
  always_comb begin
    enter_cmd_d = 1'b0;
    if (state_q == IDLE && csn_fall) begin
      enter_cmd_d = 1'b1;
    end else if (state_q == ENDT && (restart_q || csn_fall)) begin
      enter_cmd_d = 1'b1;
    end
  end

  // Transaction FSM with registered write-bus and end-of-transaction outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      restart_q <= 1'b0;
      wdata_q   <= 8'h00;
      wcmd_q    <= 1'b0;
      wstb_q    <= 1'b0;
      bcnt_q    <= '0;
      end_q     <= 1'b0;
    end else begin
      wstb_q <= 1'b0;
      end_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            state_q <= CMD;
          end
        end
        CMD, DATA: begin
          if (usr_mosi_stb) begin
            wstb_q  <= 1'b1;
            wdata_q <= usr_mosi_data;
            if (state_q == CMD) begin
              wcmd_q  <= 1'b1;
              bcnt_q  <= '0;
              state_q <= DATA;
            end else begin
              wcmd_q <= 1'b0;
              if (bcnt_q != {BCNT_W{1'b1}}) begin
                bcnt_q <= bcnt_q + 1'b1;
              end
            end
          end
          // A csn_fall here means the rise was missed: close this transaction, then reopen.
          if (csn_rise || csn_fall) begin
            state_q   <= ENDT;
            restart_q <= csn_fall;
          end
        end
        ENDT: begin
          end_q     <= 1'b1;
          restart_q <= 1'b0;
          state_q   <= enter_cmd_d ? CMD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // MISO buffer: status on transaction start, then decoder bytes; an ack consumes the byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q     <= FILL_BYTE;
      buf_vld_q <= 1'b0;
    end else if (enter_cmd_d) begin
      buf_q     <= status;
      buf_vld_q <= 1'b1;
    end else if (pw_rstb && state_q != IDLE) begin
      buf_q     <= pw_rdata;
      buf_vld_q <= 1'b1;
    end else if (usr_miso_ack) begin
      buf_vld_q <= 1'b0;
    end
  end

  assign usr_miso_data = buf_vld_q ? buf_q : FILL_BYTE;
  assign pw_wdata      = wdata_q;
  assign pw_wcmd       = wcmd_q;
  assign pw_wstb       = wstb_q;
  assign pw_bcnt       = bcnt_q;
  assign pw_end        = end_q;

endmodule

// File: tb/tb_spi_dev_proto.sv
module tb_spi_dev_proto;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] usr_mosi_data;
  logic       usr_mosi_stb;
  logic       usr_miso_ack;
  logic       csn_fall;
  logic       csn_rise;
  logic [7:0] status;
  logic [7:0] pw_rdata;
  logic       pw_rstb;

  logic [7:0] miso_a, wdata_a, miso_b, wdata_b;
  logic       wcmd_a, wstb_a, end_a, wcmd_b, wstb_b, end_b;
  logic [7:0] bcnt_a;
  logic [1:0] bcnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_dev_proto #(.FILL_BYTE(8'h00), .BCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .usr_mosi_data(usr_mosi_data), .usr_mosi_stb(usr_mosi_stb),
    .usr_miso_data(miso_a), .usr_miso_ack(usr_miso_ack),
    .csn_fall(csn_fall), .csn_rise(csn_rise), .status(status),
    .pw_wdata(wdata_a), .pw_wcmd(wcmd_a), .pw_wstb(wstb_a), .pw_bcnt(bcnt_a),
    .pw_rdata(pw_rdata), .pw_rstb(pw_rstb), .pw_end(end_a)
  );

  spi_dev_proto #(.FILL_BYTE(8'h00), .BCNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .usr_mosi_data(usr_mosi_data), .usr_mosi_stb(usr_mosi_stb),
    .usr_miso_data(miso_b), .usr_miso_ack(usr_miso_ack),
    .csn_fall(csn_fall), .csn_rise(csn_rise), .status(status),
    .pw_wdata(wdata_b), .pw_wcmd(wcmd_b), .pw_wstb(wstb_b), .pw_bcnt(bcnt_b),
    .pw_rdata(pw_rdata), .pw_rstb(pw_rstb), .pw_end(end_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one MOSI byte for a single cycle; outputs are then at N+1.
  task automatic send(input logic [7:0] b);
    usr_mosi_data = b;
    usr_mosi_stb  = 1'b1;
    tick();
    usr_mosi_stb  = 1'b0;
  endtask

  task automatic pulse_fall();
    csn_fall = 1'b1;
    tick();
    csn_fall = 1'b0;
  endtask

  task automatic pulse_rise();
    csn_rise = 1'b1;
    tick();
    csn_rise = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; usr_mosi_data = 8'h00; usr_mosi_stb = 1'b0; usr_miso_ack = 1'b0;
    csn_fall = 1'b0; csn_rise = 1'b0; status = 8'h00; pw_rdata = 8'h00; pw_rstb = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_wstb", wstb_a, 0);
    chk("rst_wcmd", wcmd_a, 0);
    chk("rst_end", end_a, 0);
    chk("rst_wdata", wdata_a, 8'h00);
    chk("rst_bcnt", bcnt_a, 0);
    chk("rst_miso", miso_a, 8'h00);
    rst_n = 1'b1;
    tick();

    // Byte ignored while idle
    send(8'h77);
    chk("idle_wstb", wstb_a, 0);

    // Tests 1 and 2: A5,01,02 with status 3C returned first
    status = 8'h3C;
    pulse_fall();
    chk("t2_miso_status", miso_a, 8'h3C);
    usr_miso_ack = 1'b1;
    send(8'hA5);
    usr_miso_ack = 1'b0;
    chk("t1_wstb0", wstb_a, 1);
    chk("t1_wcmd0", wcmd_a, 1);
    chk("t1_wdata0", wdata_a, 8'hA5);
    chk("t1_bcnt0", bcnt_a, 0);
    chk("t2_miso_fill", miso_a, 8'h00);
    tick();
    chk("t1_gap_wstb", wstb_a, 0);
    chk("t1_hold_wdata", wdata_a, 8'hA5);
    send(8'h01);
    chk("t1_wstb1", wstb_a, 1);
    chk("t1_wcmd1", wcmd_a, 0);
    chk("t1_wdata1", wdata_a, 8'h01);
    chk("t1_bcnt1", bcnt_a, 1);
    usr_miso_ack = 1'b1;
    send(8'h02);
    usr_miso_ack = 1'b0;
    chk("t1_wcmd2", wcmd_a, 0);
    chk("t1_bcnt2", bcnt_a, 2);
    chk("t2_miso_fill2", miso_a, 8'h00);
    pulse_rise();
    chk("t1_end_early", end_a, 0);
    tick();
    chk("t1_end", end_a, 1);
    tick();
    chk("t1_end_once", end_a, 0);

    // Test 3: pw_rstb and ack together, new byte wins
    status = 8'h10;
    pulse_fall();
    pw_rdata = 8'h99; pw_rstb = 1'b1; usr_miso_ack = 1'b1;
    tick();
    pw_rstb = 1'b0; usr_miso_ack = 1'b0;
    chk("t3_miso_new", miso_a, 8'h99);
    usr_miso_ack = 1'b1;
    tick();
    usr_miso_ack = 1'b0;
    chk("t3_miso_acked", miso_a, 8'h00);

    // Test 4: byte coincident with csn_rise
    send(8'h11);
    chk("t4_cmd", wcmd_a, 1);
    usr_mosi_data = 8'h22; usr_mosi_stb = 1'b1; csn_rise = 1'b1;
    tick();
    usr_mosi_stb = 1'b0; csn_rise = 1'b0;
    chk("t4_wstb_n1", wstb_a, 1);
    chk("t4_wdata_n1", wdata_a, 8'h22);
    chk("t4_end_n1", end_a, 0);
    tick();
    chk("t4_wstb_n2", wstb_a, 0);
    chk("t4_end_n2", end_a, 1);
    tick();
    chk("t4_end_n3", end_a, 0);

    // Test 5: six back-to-back bytes, bcnt saturates on the 2-bit instance
    pulse_fall();
    usr_mosi_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      usr_mosi_data = 8'h40 + 8'(i);
      tick();
      chk($sformatf("t5_bcnt8_%0d", i), bcnt_a, i);
      chk($sformatf("t5_bcnt2_%0d", i), bcnt_b, (i > 3) ? 3 : i);
      chk($sformatf("t5_wstb2_%0d", i), wstb_b, 1);
    end
    usr_mosi_stb = 1'b0;
    pulse_rise();
    tick();
    chk("t5_end", end_b, 1);
    tick();

    // Test 6: reset mid-transaction
    pulse_fall();
    send(8'h55);
    chk("t6_pre_wstb", wstb_a, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_wstb", wstb_a, 0);
    for (int i = 0; i < 3; i++) begin
      send(8'h60 + 8'(i));
      chk($sformatf("t6_wstb_%0d", i), wstb_a, 0);
      chk($sformatf("t6_end_%0d", i), end_a, 0);
    end
    pulse_rise();
    tick();
    chk("t6_end_rise", end_a, 0);
    tick();
    chk("t6_end_rise2", end_a, 0);
    pulse_fall();
    send(8'h66);
    chk("t6_resume_wcmd", wcmd_a, 1);
    chk("t6_resume_bcnt", bcnt_a, 0);
    send(8'h67);
    chk("t6_resume_bcnt1", bcnt_a, 1);

    // Test 7: csn_fall without a preceding csn_rise
    status = 8'h5A;
    pulse_fall();
    chk("t7_end_n1", end_a, 0);
    tick();
    chk("t7_end_n2", end_a, 1);
    chk("t7_miso_status", miso_a, 8'h5A);
    send(8'h80);
    chk("t7_end_cleared", end_a, 0);
    chk("t7_wstb", wstb_a, 1);
    chk("t7_wcmd", wcmd_a, 1);
    chk("t7_bcnt", bcnt_a, 0);
    chk("t7_wdata", wdata_a, 8'h80);

    // Close out
    pulse_rise();
    tick();
    chk("t7_final_end", end_a, 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
